seq_gen: RTL and testbench

// - Serial pattern transmitter; the transmit-side counterpart of seq_det. Shifts a PAT_W-bit

---
 rtl/seq_gen.sv | 149 ++++++++++++++
 tb/tb_seq_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB first, repeated per request.
// Latency: first bit one cycle after start is accepted; all outputs registered; no backpressure.
module seq_gen #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int                REP_W   = 4,
  parameter int                GAP_CYC = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             use_ext,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(PAT_W);
  localparam int GCW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(PAT_W - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0] frames_q, frames_d;
  logic             seq_out_q, seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PAT_W-1:0] cap_pat;

  assign cap_pat = use_ext ? pattern_in : PATTERN;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frames_d    = frames_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d       = cap_pat;
          sh_d        = cap_pat << 1;
          frames_d    = (reps == '0) ? REP_W'(1) : reps;
          bit_cnt_d   = '0;
          seq_out_d   = cap_pat[PAT_W-1];
          seq_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q == BIT_LAST) begin
          if (frames_q > REP_W'(1)) begin
            frames_d  = frames_q - REP_W'(1);
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            if (GAP_CYC == 0) begin
              seq_out_d   = pat_q[PAT_W-1];
              sh_d        = pat_q << 1;
              seq_valid_d = 1'b1;
            end else begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          bit_cnt_d   = bit_cnt_q + BCW'(1);
          seq_out_d   = sh_q[PAT_W-1];
          sh_d        = sh_q << 1;
          seq_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          // Gap over: the next frame's MSB goes out on the same edge that leaves GAP.
          bit_cnt_d   = '0;
          seq_out_d   = pat_q[PAT_W-1];
          sh_d        = pat_q << 1;
          seq_valid_d = 1'b1;
          state_d     = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frames_q    <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frames_q    <= frames_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a back-to-back instance and a GAP_CYC=2 instance driven by the same inputs.
module tb_seq_gen;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       use_ext = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic [3:0] reps = 4'd0;
  logic       abort = 1'b0;
  logic       seq_out0, seq_valid0, busy0, done0;
  logic       seq_out1, seq_valid1, busy1, done1;

  int total = 0;
  int bad = 0;
  int q0[$];
  int q1[$];

  always #5 clock = ~clock;

  seq_gen #(.PAT_W(4), .PATTERN(4'b1011), .REP_W(4), .GAP_CYC(0)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .use_ext(use_ext),
    .pattern_in(pattern_in), .reps(reps), .abort(abort),
    .seq_out(seq_out0), .seq_valid(seq_valid0), .busy(busy0), .done(done0)
  );

  seq_gen #(.PAT_W(4), .PATTERN(4'b1011), .REP_W(4), .GAP_CYC(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .use_ext(use_ext),
    .pattern_in(pattern_in), .reps(reps), .abort(abort),
    .seq_out(seq_out1), .seq_valid(seq_valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: each valid bit pops its expected value (0/1), a done pulse pops 2.
  always @(negedge clock) begin
    if (seq_valid0 || done0) begin
      if (q0.size() == 0) chk("dut0 unexpected output", done0 ? 2 : int'(seq_out0), -1);
      else chk("dut0 stream", done0 ? 2 : int'(seq_out0), q0.pop_front());
    end
  end

  always @(negedge clock) begin
    if (seq_valid1 || done1) begin
      if (q1.size() == 0) chk("dut1 unexpected output", done1 ? 2 : int'(seq_out1), -1);
      else chk("dut1 stream", done1 ? 2 : int'(seq_out1), q1.pop_front());
    end
  end

  // mode: 0 normal, 1 start/pattern poke mid-frame, 2 abort on 2nd bit,
  //       3 reset on 2nd bit with start held during reset, 4 reset in DONE
  task automatic send(input logic ue, input logic [3:0] pat, input logic [3:0] r,
                      input int mode, input string nm);
    int f, d0, d1, b0, b1;
    logic [3:0] p;
    f = (r == 4'd0) ? 1 : int'(r);
    p = ue ? pat : 4'b1011;
    if (mode == 2 || mode == 3) begin
      q0.push_back(int'(p[3])); q0.push_back(int'(p[2]));
      q1.push_back(int'(p[3])); q1.push_back(int'(p[2]));
    end else begin
      for (int fr = 0; fr < f; fr++)
        for (int i = 3; i >= 0; i--) begin
          q0.push_back(int'(p[i]));
          q1.push_back(int'(p[i]));
        end
      q0.push_back(2);
      q1.push_back(2);
    end
    @(negedge clock);
    use_ext = ue; pattern_in = pat; reps = r; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    d0 = 0; d1 = 0; b0 = 0; b1 = 0;
    // c counts cycles after the start edge (c=1 is the first bit cycle).
    for (int c = 1; c <= 60; c++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0 && d0 == 0) d0 = c;
      if (done1 && d1 == 0) d1 = c;
      if (mode == 1 && c == 2) begin
        start = 1'b1; pattern_in = ~pat; use_ext = ~ue; reps = 4'd9;
      end
      if (mode == 1 && c == 3) start = 1'b0;
      if (mode == 2 && c == 2) abort = 1'b1;
      if (mode == 3 && c == 2) reset = 1'b0;
      if ((mode == 2 || mode == 3) && c >= 3) begin
        if (c == 3) begin abort = 1'b0; start = (mode == 3); end
        chk({nm, " outputs idle"},
            int'({seq_out0, seq_valid0, busy0, done0, seq_out1, seq_valid1, busy1, done1}), 0);
      end
      if (mode == 3 && c == 5) begin reset = 1'b1; start = 1'b0; end
      if (mode == 4 && c == 5) reset = 1'b0;
      if (mode == 4 && c == 6) begin
        reset = 1'b1;
        chk({nm, " outputs idle"},
            int'({seq_out0, seq_valid0, busy0, done0, seq_out1, seq_valid1, busy1, done1}), 0);
      end
      if ((mode == 2 || mode == 3) && c == 12) break;
      if (mode != 2 && mode != 3 && d0 != 0 && d1 != 0 && (mode != 4 || c >= 6)) break;
      @(negedge clock);
    end
    if (mode != 2 && mode != 3) begin
      chk({nm, " dut0 done cycle"}, d0, f * 4 + 1);
      chk({nm, " dut1 done cycle"}, d1, f * 4 + (f - 1) * 2 + 1);
      chk({nm, " dut0 busy cycles"}, b0, f * 4);
      chk({nm, " dut1 busy cycles"}, b1, f * 4 + (f - 1) * 2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset outputs",
        int'({seq_out0, seq_valid0, busy0, done0, seq_out1, seq_valid1, busy1, done1}), 0);
    reset = 1'b1;
    @(negedge clock);
    send(1'b0, 4'b0000, 4'd1, 0, "default reps1");
    send(1'b0, 4'b0000, 4'd3, 0, "default reps3");
    send(1'b1, 4'b0110, 4'd2, 0, "ext 0110 reps2");
    send(1'b0, 4'b0000, 4'd0, 0, "reps0");
    send(1'b1, 4'b1100, 4'd2, 1, "mid-frame poke");
    send(1'b1, 4'b1001, 4'd2, 2, "abort");
    send(1'b1, 4'b0101, 4'd1, 0, "after abort");
    send(1'b1, 4'b1110, 4'd2, 3, "reset mid-frame");
    send(1'b1, 4'b0011, 4'd1, 0, "after reset");
    send(1'b0, 4'b0000, 4'd1, 4, "reset in done");
    repeat (3) @(negedge clock);
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
